// File: rtl/alu_issue_scheduler_if.sv
// Dispatch, writeback, flush and issue signals of the ALU issue scheduler,
// bundled so the scheduler and its neighbours share one port list.
interface alu_issue_scheduler_if #(
  parameter int ENTRY_NUM   = 8,
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int RRF_TAG_W   = 6,
  parameter int ALU_OP_W    = 4,
  parameter int SRC_A_SEL_W = 2,
  parameter int SRC_B_SEL_W = 2
);
  localparam int CNT_W = $clog2(ENTRY_NUM) + 1;

  logic                   dp_valid_i;
  logic                   dp_ready_o;
  logic [ADDR_LEN-1:0]    dp_pc_i;
  logic [DATA_LEN-1:0]    dp_imm_i;
  logic [ALU_OP_W-1:0]    dp_alu_op_i;
  logic [SRC_A_SEL_W-1:0] dp_src_a_sel_i;
  logic [SRC_B_SEL_W-1:0] dp_src_b_sel_i;
  logic [DATA_LEN-1:0]    dp_src1_i;
  logic                   dp_rdy1_i;
  logic [DATA_LEN-1:0]    dp_src2_i;
  logic                   dp_rdy2_i;
  logic [RRF_TAG_W-1:0]   dp_dst_tag_i;
  logic                   dp_write_rrf_i;

  logic                   wb_valid_i;
  logic [RRF_TAG_W-1:0]   wb_tag_i;
  logic [DATA_LEN-1:0]    wb_data_i;
  logic                   kill_i;

  logic                   issue_o;
  logic [ADDR_LEN-1:0]    pc_o;
  logic [DATA_LEN-1:0]    imm_o;
  logic [ALU_OP_W-1:0]    alu_op_o;
  logic [DATA_LEN-1:0]    src1_o;
  logic [DATA_LEN-1:0]    src2_o;
  logic [SRC_A_SEL_W-1:0] src_a_sel_o;
  logic [SRC_B_SEL_W-1:0] src_b_sel_o;
  logic [RRF_TAG_W-1:0]   dst_tag_o;
  logic                   if_write_rrf_o;
  logic [CNT_W-1:0]       count_o;

  modport master (
    output dp_valid_i, dp_pc_i, dp_imm_i, dp_alu_op_i, dp_src_a_sel_i,
           dp_src_b_sel_i, dp_src1_i, dp_rdy1_i, dp_src2_i, dp_rdy2_i,
           dp_dst_tag_i, dp_write_rrf_i, wb_valid_i, wb_tag_i, wb_data_i, kill_i,
    input  dp_ready_o, issue_o, pc_o, imm_o, alu_op_o, src1_o, src2_o,
           src_a_sel_o, src_b_sel_o, dst_tag_o, if_write_rrf_o, count_o
  );

  modport slave (
    input  dp_valid_i, dp_pc_i, dp_imm_i, dp_alu_op_i, dp_src_a_sel_i,
           dp_src_b_sel_i, dp_src1_i, dp_rdy1_i, dp_src2_i, dp_rdy2_i,
           dp_dst_tag_i, dp_write_rrf_i, wb_valid_i, wb_tag_i, wb_data_i, kill_i,
    output dp_ready_o, issue_o, pc_o, imm_o, alu_op_o, src1_o, src2_o,
           src_a_sel_o, src_b_sel_o, dst_tag_o, if_write_rrf_o, count_o
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Reservation station for the ALU: buffers dispatched ops, wakes operands from
// the writeback bus and issues the oldest ready entry through a register stage.
module alu_issue_scheduler #(
  parameter int ENTRY_NUM   = 8,
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int RRF_TAG_W   = 6,
  parameter int ALU_OP_W    = 4,
  parameter int SRC_A_SEL_W = 2,
  parameter int SRC_B_SEL_W = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  alu_issue_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [ADDR_LEN-1:0]    pc;
    logic [DATA_LEN-1:0]    imm;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [SRC_A_SEL_W-1:0] a_sel;
    logic [SRC_B_SEL_W-1:0] b_sel;
    logic [DATA_LEN-1:0]    src1;
    logic [DATA_LEN-1:0]    src2;
    logic [RRF_TAG_W-1:0]   dst_tag;
    logic                   write_rrf;
  } issue_t;

  typedef struct packed {
    issue_t op;
    logic   rdy1;
    logic   rdy2;
  } entry_t;

  entry_t                 ent_q   [ENTRY_NUM];
  entry_t                 ent_d   [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   valid_q, valid_d;
  // older_q[i][j] set means entry i was allocated before entry j
  logic [ENTRY_NUM-1:0]   older_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   older_d [ENTRY_NUM];
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   issue_q, issue_d;
  issue_t                 out_q, out_d;

  logic                   dp_ready;
  logic                   accept;
  logic [IDX_W-1:0]       free_idx;
  logic [ENTRY_NUM-1:0]   eligible;
  logic [ENTRY_NUM-1:0]   sel_oh;
  logic                   sel_any;
  logic [IDX_W-1:0]       sel_idx;
  entry_t                 new_ent;

  function automatic logic wb_hit(input logic                 rdy,
                                  input logic [DATA_LEN-1:0]  src,
                                  input logic                 wb_v,
                                  input logic [RRF_TAG_W-1:0] wb_tag);
    return !rdy && wb_v && (src[RRF_TAG_W-1:0] == wb_tag);
  endfunction

  assign dp_ready = (count_q != CNT_W'(ENTRY_NUM));
  assign accept   = bus.dp_valid_i && dp_ready;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Oldest-ready select: an eligible entry loses if any other eligible entry is older.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      eligible[i] = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
    sel_oh = eligible;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      for (int j = 0; j < ENTRY_NUM; j++) begin
        if (eligible[j] && older_q[j][i]) sel_oh[i] = 1'b0;
      end
    end
    sel_any = |sel_oh;
    sel_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    new_ent.op.pc        = bus.dp_pc_i;
    new_ent.op.imm       = bus.dp_imm_i;
    new_ent.op.alu_op    = bus.dp_alu_op_i;
    new_ent.op.a_sel     = bus.dp_src_a_sel_i;
    new_ent.op.b_sel     = bus.dp_src_b_sel_i;
    new_ent.op.src1      = bus.dp_src1_i;
    new_ent.op.src2      = bus.dp_src2_i;
    new_ent.op.dst_tag   = bus.dp_dst_tag_i;
    new_ent.op.write_rrf = bus.dp_write_rrf_i;
    new_ent.rdy1         = bus.dp_rdy1_i;
    new_ent.rdy2         = bus.dp_rdy2_i;
    // Same-cycle writeback would otherwise be missed by a freshly written entry
    if (wb_hit(bus.dp_rdy1_i, bus.dp_src1_i, bus.wb_valid_i, bus.wb_tag_i)) begin
      new_ent.op.src1 = bus.wb_data_i;
      new_ent.rdy1    = 1'b1;
    end
    if (wb_hit(bus.dp_rdy2_i, bus.dp_src2_i, bus.wb_valid_i, bus.wb_tag_i)) begin
      new_ent.op.src2 = bus.wb_data_i;
      new_ent.rdy2    = 1'b1;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    older_d = older_q;
    count_d = count_q;
    issue_d = 1'b0;
    out_d   = out_q;
    if (bus.kill_i) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (valid_q[i]) begin
          if (wb_hit(ent_q[i].rdy1, ent_q[i].op.src1, bus.wb_valid_i, bus.wb_tag_i)) begin
            ent_d[i].op.src1 = bus.wb_data_i;
            ent_d[i].rdy1    = 1'b1;
          end
          if (wb_hit(ent_q[i].rdy2, ent_q[i].op.src2, bus.wb_valid_i, bus.wb_tag_i)) begin
            ent_d[i].op.src2 = bus.wb_data_i;
            ent_d[i].rdy2    = 1'b1;
          end
        end
      end
      if (sel_any) begin
        valid_d[sel_idx] = 1'b0;
        issue_d          = 1'b1;
        out_d            = ent_q[sel_idx].op;
      end
      if (accept) begin
        ent_d[free_idx]   = new_ent;
        valid_d[free_idx] = 1'b1;
        older_d[free_idx] = '0;
        for (int j = 0; j < ENTRY_NUM; j++) begin
          older_d[j][free_idx] = valid_q[j];
        end
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, sel_any};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      count_q <= '0;
      issue_q <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      issue_q <= issue_d;
      out_q   <= out_d;
      older_q <= older_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  assign bus.dp_ready_o     = dp_ready;
  assign bus.count_o        = count_q;
  assign bus.issue_o        = issue_q;
  assign bus.pc_o           = out_q.pc;
  assign bus.imm_o          = out_q.imm;
  assign bus.alu_op_o       = out_q.alu_op;
  assign bus.src_a_sel_o    = out_q.a_sel;
  assign bus.src_b_sel_o    = out_q.b_sel;
  assign bus.src1_o         = out_q.src1;
  assign bus.src2_o         = out_q.src2;
  assign bus.dst_tag_o      = out_q.dst_tag;
  assign bus.if_write_rrf_o = out_q.write_rrf;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: expected issue packets are queued in
// issue order as stimulus is driven and compared whenever issue_o is seen.
module tb_alu_issue_scheduler;
  localparam int ENTRY_NUM = 8;
  localparam int CNT_W     = $clog2(ENTRY_NUM) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [5:0]  tag;
    logic        wrrf;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.ENTRY_NUM(ENTRY_NUM), .DATA_LEN(32), .ADDR_LEN(32),
    .RRF_TAG_W(6), .ALU_OP_W(4), .SRC_A_SEL_W(2), .SRC_B_SEL_W(2)) bus ();

  alu_issue_scheduler #(.ENTRY_NUM(ENTRY_NUM), .DATA_LEN(32), .ADDR_LEN(32),
    .RRF_TAG_W(6), .ALU_OP_W(4), .SRC_A_SEL_W(2), .SRC_B_SEL_W(2)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  pkt_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic pkt_t mk(input logic [31:0] pc, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [5:0] tag);
    pkt_t p;
    p.pc   = pc;
    p.imm  = pc + 32'h1000;
    p.op   = pc[5:2];
    p.asel = pc[3:2];
    p.bsel = pc[5:4];
    p.s1   = s1;
    p.s2   = s2;
    p.tag  = tag;
    p.wrrf = tag[0];
    return p;
  endfunction

  function automatic pkt_t seen();
    pkt_t p;
    p.pc   = bus.pc_o;
    p.imm  = bus.imm_o;
    p.op   = bus.alu_op_o;
    p.asel = bus.src_a_sel_o;
    p.bsel = bus.src_b_sel_o;
    p.s1   = bus.src1_o;
    p.s2   = bus.src2_o;
    p.tag  = bus.dst_tag_o;
    p.wrrf = bus.if_write_rrf_o;
    return p;
  endfunction

  task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    pkt_t e;
    @(posedge clk);
    #1;
    if (bus.issue_o === 1'b1) begin
      check("sb_has_entry", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_pkt", seen(), e);
      end
    end
  endtask

  task automatic idle();
    bus.dp_valid_i = 1'b0;
    bus.wb_valid_i = 1'b0;
    bus.kill_i     = 1'b0;
  endtask

  task automatic dp(input pkt_t p, input logic r1, input logic r2);
    bus.dp_valid_i     = 1'b1;
    bus.dp_pc_i        = p.pc;
    bus.dp_imm_i       = p.imm;
    bus.dp_alu_op_i    = p.op;
    bus.dp_src_a_sel_i = p.asel;
    bus.dp_src_b_sel_i = p.bsel;
    bus.dp_src1_i      = p.s1;
    bus.dp_rdy1_i      = r1;
    bus.dp_src2_i      = p.s2;
    bus.dp_rdy2_i      = r2;
    bus.dp_dst_tag_i   = p.tag;
    bus.dp_write_rrf_i = p.wrrf;
  endtask

  task automatic wb(input logic [5:0] tag, input logic [31:0] data);
    bus.wb_valid_i = 1'b1;
    bus.wb_tag_i   = tag;
    bus.wb_data_i  = data;
  endtask

  initial begin
    idle();
    dp(mk(32'h0, 32'h0, 32'h0, 6'h0), 1'b0, 1'b0);
    bus.dp_valid_i = 1'b0;
    wb(6'h0, 32'h0);
    bus.wb_valid_i = 1'b0;

    // Reset state
    #12;
    check("rst_issue", bus.issue_o, 1'b0);
    check("rst_count", bus.count_o, 0);
    check("rst_ready", bus.dp_ready_o, 1'b1);
    check("rst_pc_o", bus.pc_o, 0);
    check("rst_src1_o", bus.src1_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fully-ready ADD
    exp_q.push_back(mk(32'h100, 32'd5, 32'd7, 6'd3));
    dp(mk(32'h100, 32'd5, 32'd7, 6'd3), 1'b1, 1'b1);
    tick();
    check("t1_count_acc", bus.count_o, 1);
    check("t1_no_issue_yet", bus.issue_o, 1'b0);
    idle();
    tick();
    check("t1_issue", bus.issue_o, 1'b1);
    check("t1_src1", bus.src1_o, 5);
    check("t1_src2", bus.src2_o, 7);
    check("t1_dst", bus.dst_tag_o, 3);
    check("t1_count_end", bus.count_o, 0);

    // Waiting A overtaken by ready B, then A wakes
    dp(mk(32'h200, 32'd1, 32'd9, 6'd10), 1'b1, 1'b0);
    tick();
    exp_q.push_back(mk(32'h204, 32'd2, 32'd3, 6'd11));
    dp(mk(32'h204, 32'd2, 32'd3, 6'd11), 1'b1, 1'b1);
    tick();
    idle();
    tick();
    check("t2_b_issue", bus.issue_o, 1'b1);
    check("t2_b_dst", bus.dst_tag_o, 11);
    exp_q.push_back(mk(32'h200, 32'd1, 32'h55, 6'd10));
    wb(6'd9, 32'h55);
    tick();
    check("t2_wake_no_issue", bus.issue_o, 1'b0);
    idle();
    tick();
    check("t2_a_issue", bus.issue_o, 1'b1);
    check("t2_a_src2", bus.src2_o, 32'h55);
    check("t2_count", bus.count_o, 0);

    // Age order independent of slot index: E0 in slot 2, E1 in 0, E2 in 1
    dp(mk(32'h300, 32'd20, 32'd1, 6'd20), 1'b0, 1'b1); tick();
    dp(mk(32'h304, 32'd21, 32'd1, 6'd21), 1'b0, 1'b1); tick();
    dp(mk(32'h308, 32'd22, 32'd1, 6'd22), 1'b0, 1'b1); tick();
    idle();
    exp_q.push_back(mk(32'h308, 32'h2222, 32'd1, 6'd22));
    wb(6'd22, 32'h2222); tick();
    idle(); tick();
    check("t3_w2_issue", bus.issue_o, 1'b1);
    dp(mk(32'h310, 32'd30, 32'h1000, 6'd40), 1'b0, 1'b1); tick();
    idle();
    exp_q.push_back(mk(32'h300, 32'h2020, 32'd1, 6'd20));
    wb(6'd20, 32'h2020); tick();
    exp_q.push_back(mk(32'h304, 32'h2121, 32'd1, 6'd21));
    wb(6'd21, 32'h2121); tick();
    idle(); tick();
    dp(mk(32'h314, 32'd30, 32'h1001, 6'd41), 1'b0, 1'b1); tick();
    dp(mk(32'h318, 32'd30, 32'h1002, 6'd42), 1'b0, 1'b1); tick();
    idle();
    check("t3_count3", bus.count_o, 3);
    exp_q.push_back(mk(32'h310, 32'h77, 32'h1000, 6'd40));
    exp_q.push_back(mk(32'h314, 32'h77, 32'h1001, 6'd41));
    exp_q.push_back(mk(32'h318, 32'h77, 32'h1002, 6'd42));
    wb(6'd30, 32'h77); tick();
    check("t3_wake_no_issue", bus.issue_o, 1'b0);
    idle();
    tick(); check("t3_e0", bus.dst_tag_o, 40);
    tick(); check("t3_e1", bus.dst_tag_o, 41);
    tick(); check("t3_e2", bus.dst_tag_o, 42);
    tick();
    check("t3_idle", bus.issue_o, 1'b0);
    check("t3_count", bus.count_o, 0);

    // Fill all entries, reject a ninth, drain oldest first
    for (int i = 0; i < ENTRY_NUM; i++) begin
      dp(mk(32'h400 + 32'(4 * i), 32'd4, 32'(100 + i), 6'(50 + i)), 1'b0, 1'b1);
      tick();
    end
    check("t4_full_count", bus.count_o, ENTRY_NUM);
    check("t4_not_ready", bus.dp_ready_o, 1'b0);
    dp(mk(32'h4f0, 32'd1, 32'd1, 6'd63), 1'b1, 1'b1);
    tick();
    check("t4_ninth_ignored", bus.count_o, ENTRY_NUM);
    idle();
    for (int i = 0; i < ENTRY_NUM; i++) begin
      exp_q.push_back(mk(32'h400 + 32'(4 * i), 32'h44, 32'(100 + i), 6'(50 + i)));
    end
    wb(6'd4, 32'h44);
    tick();
    check("t4_wake_no_issue", bus.issue_o, 1'b0);
    idle();
    for (int i = 0; i < ENTRY_NUM; i++) begin
      tick();
      check("t4_drain_issue", bus.issue_o, 1'b1);
      if (i == 0) begin
        check("t4_ready_after_first", bus.dp_ready_o, 1'b1);
        check("t4_count_after_first", bus.count_o, ENTRY_NUM - 1);
      end
    end
    tick();
    check("t4_idle", bus.issue_o, 1'b0);
    check("t4_count", bus.count_o, 0);

    // Dispatch bypass of a same-cycle writeback
    exp_q.push_back(mk(32'h500, 32'hAB, 32'd2, 6'd12));
    dp(mk(32'h500, 32'd12, 32'd2, 6'd12), 1'b0, 1'b1);
    wb(6'd12, 32'hAB);
    tick();
    idle();
    tick();
    check("t5_issue", bus.issue_o, 1'b1);
    check("t5_src1", bus.src1_o, 32'hAB);

    // Kill with eligible entries, simultaneous dispatch and wakeup
    for (int i = 0; i < 5; i++) begin
      dp(mk(32'h600 + 32'(4 * i), 32'd40, 32'd3, 6'(20 + i)), 1'b0, 1'b1);
      tick();
    end
    idle();
    check("t6_count5", bus.count_o, 5);
    wb(6'd40, 32'h4040);
    tick();
    check("t6_pre_kill_no_issue", bus.issue_o, 1'b0);
    bus.kill_i = 1'b1;
    dp(mk(32'h6f0, 32'd1, 32'd2, 6'd33), 1'b1, 1'b1);
    wb(6'd40, 32'h1);
    tick();
    check("t6_kill_count", bus.count_o, 0);
    check("t6_kill_issue", bus.issue_o, 1'b0);
    check("t6_kill_ready", bus.dp_ready_o, 1'b1);
    idle();
    tick();
    check("t6_no_leftover", bus.issue_o, 1'b0);
    wb(6'd40, 32'h2);
    tick();
    idle();
    tick();
    check("t6_no_rewake", bus.issue_o, 1'b0);
    exp_q.push_back(mk(32'h700, 32'd8, 32'd9, 6'd34));
    dp(mk(32'h700, 32'd8, 32'd9, 6'd34), 1'b1, 1'b1);
    tick();
    check("t6_alloc_count", bus.count_o, 1);
    idle();
    tick();
    check("t6_post_issue", bus.issue_o, 1'b1);
    check("t6_post_dst", bus.dst_tag_o, 34);

    // Asynchronous reset mid-operation
    dp(mk(32'h800, 32'd1, 32'd1, 6'd35), 1'b1, 1'b1);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_count", bus.count_o, 0);
    check("t7_rst_issue", bus.issue_o, 1'b0);
    check("t7_rst_ready", bus.dp_ready_o, 1'b1);
    check("t7_rst_pc", bus.pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("t7_no_partial_issue", bus.issue_o, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
